// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed multi-digit 7-segment driver.
// Scans one digit per slot over a shared active-low segment bus. Each slot
// begins with a short guard interval during which every digit is disabled.
// Updates are tear-free: new values are staged and only reach the displayed
// (shadow) set at a frame boundary. Also provides leading-zero blanking,
// per-digit decimal point and per-digit blink.
//
// Load handshake: iLoad is a one-cycle strobe with no back-pressure. Every
// cycle iLoad is high, iValue/iDpMask/iBlinkMask are captured and the latest
// capture wins. A capture becomes visible from the next frame start. A
// capture made in the frame-boundary cycle itself is visible from that very
// frame start.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    iCLK,
   input  logic                    iRST_n,
   input  logic [4*NUM_DIGITS-1:0] iValue,
   input  logic [NUM_DIGITS-1:0]   iDpMask,
   input  logic [NUM_DIGITS-1:0]   iBlinkMask,
   input  logic                    iLoad,
   input  logic                    iLzbEn,
   output logic [6:0]              oSEG7,
   output logic                    oDP,
   output logic [NUM_DIGITS-1:0]   oDigitSel,
   output logic                    oFrameStart
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [FW-1:0]           frame_cnt;
   logic                    blink_on;
   logic                    pending;
   logic [4*NUM_DIGITS-1:0] staged_value, shadow_value;
   logic [NUM_DIGITS-1:0]   staged_dp, shadow_dp;
   logic [NUM_DIGITS-1:0]   staged_blink, shadow_blink;
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic                    lz_run;
   logic                    slot_end, frame_end, in_guard, blink_off;
   logic [3:0]              cur_digit;
   logic [6:0]              seg_n;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   sel_n;

   // Active-low hex glyphs, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0011000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
   assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
   assign in_guard  = (32'(cnt) < GUARD);

   // Slot counter and scan index; idx moves on at the end of each slot.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (slot_end) begin
         cnt <= '0;
         idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Staging and shadow registers; shadow only changes at a frame boundary.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         pending      <= 1'b0;
         staged_value <= '0;
         staged_dp    <= '0;
         staged_blink <= '0;
         shadow_value <= '0;
         shadow_dp    <= '0;
         shadow_blink <= '0;
      end else if (frame_end) begin
         pending <= 1'b0;
         if (iLoad) begin
            shadow_value <= iValue;
            shadow_dp    <= iDpMask;
            shadow_blink <= iBlinkMask;
         end else if (pending) begin
            shadow_value <= staged_value;
            shadow_dp    <= staged_dp;
            shadow_blink <= staged_blink;
         end
      end else if (iLoad) begin
         pending      <= 1'b1;
         staged_value <= iValue;
         staged_dp    <= iDpMask;
         staged_blink <= iBlinkMask;
      end
   end

   // Blink phase toggles after every BLINK_FRAMES completed frames.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         frame_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (frame_end) begin
         if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Leading-zero run from the top digit downwards; digit 0 is never blanked.
   always_comb begin
      lz_blank = '0;
      lz_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         if (lz_run && (shadow_value[4*i +: 4] == 4'h0)) lz_blank[i] = 1'b1;
         else                                             lz_run      = 1'b0;
      end
   end

   // Next output values from the current scan position and shadow digit.
   always_comb begin
      seg_n     = 7'h7F;
      dp_n      = 1'b1;
      sel_n     = '1;
      cur_digit = shadow_value[{idx, 2'b00} +: 4];
      blink_off = !blink_on && shadow_blink[idx];
      if (!in_guard) begin
         sel_n = ~(NUM_DIGITS'(1) << idx);
         if (!blink_off && !(iLzbEn && lz_blank[idx])) seg_n = glyph(cur_digit);
         dp_n = blink_off ? 1'b1 : ~shadow_dp[idx];
      end
   end

   // Registered pin drivers, one cycle behind (idx, cnt).
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         oSEG7       <= 7'h7F;
         oDP         <= 1'b1;
         oDigitSel   <= '1;
         oFrameStart <= 1'b0;
      end else begin
         oSEG7       <= seg_n;
         oDP         <= dp_n;
         oDigitSel   <= sel_n;
         oFrameStart <= (idx == '0) && (cnt == '0);
      end
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised, time-multiplexed multi-digit 7-segment display driver. It is the successor to the single-digit hex-to-segment decoder.
- Latches a packed multi-nibble value and scans digits one at a time on a shared segment bus with per-digit enables.
- Adds tear-free frame-synchronous update, leading-zero blanking, per-digit decimal point, per-digit blink and an anti-ghosting guard interval.
- Sits between datapath result registers and board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..16)
- REFRESH_DIV, 50000, clock cycles per digit slot (>= GUARD+1)
- GUARD, 2, cycles at start of each slot with all digits disabled (0..REFRESH_DIV-1)
- BLINK_FRAMES, 64, full scan frames per blink half-period (>= 1)

Ports:
- iCLK  in  1  clock
- iRST_n  in  1  asynchronous active-low reset
- iValue  in  4*NUM_DIGITS  packed hex digits, digit 0 = bits [3:0] (rightmost)
- iDpMask  in  NUM_DIGITS  decimal point request per digit
- iBlinkMask  in  NUM_DIGITS  blink enable per digit
- iLoad  in  1  one-cycle strobe: stage iValue/iDpMask/iBlinkMask for display
- iLzbEn  in  1  leading-zero blank enable (live, not staged)
- oSEG7  out  7  segments {g,f,e,d,c,b,a}, active-low
- oDP  out  1  decimal point, active-low
- oDigitSel  out  NUM_DIGITS  digit enables, active-low, at most one low
- oFrameStart  out  1  one-cycle pulse when digit 0 slot begins

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST_n is asynchronous and active-low.
- Reset values (immediate on iRST_n low, including mid-operation):
  - oSEG7=7'h7F, oDP=1, oDigitSel=all ones, oFrameStart=0
  - slot counter cnt=0, scan index idx=0, blink counters/phase=on
  - staged/shadow registers 0, pending=0
- Scan:
  - cnt counts 0..REFRESH_DIV-1.
  - At terminal count, cnt wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Outputs: all registered, one-cycle latency from (idx,cnt).
  - cnt < GUARD: oDigitSel=all ones, oSEG7=7'h7F, oDP=1.
  - Otherwise: oDigitSel has only bit idx low, and oSEG7/oDP carry the glyph of shadow digit idx.
- oFrameStart pulses on the edge where outputs reflect idx=0, cnt=0.
- Glyphs: hex 0-F, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Blank=1111111.
- Update protocol (tear-free):
  - iLoad copies inputs into staged regs and sets pending.
  - At a frame boundary (idx wraps to 0), if pending is set: shadow<=staged, pending cleared.
  - iLoad again while pending: staged overwritten, latest wins.
  - iLoad in the same cycle as a frame boundary: the new inputs go directly to shadow and pending ends 0.
  - Shadow never changes mid-frame.
- Leading-zero blanking: with iLzbEn=1, shadow digits from NUM_DIGITS-1 downward that equal 0 are blanked until the first nonzero digit. Digit 0 is never LZ-blanked. DP is unaffected by LZB.
- Blink:
  - Frame counter counts completed frames.
  - After each BLINK_FRAMES frames, phase toggles.
  - During the off phase, digits whose shadow blink bit is set show blank segments with oDP=1; oDigitSel is still driven.
- NUM_DIGITS=1: idx stays 0 and every slot end is a frame boundary.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2.
  - Release reset -> edge 1: oDigitSel=4'b1111. Edges 2-4: oDigitSel=4'b1110, oSEG7=7'b1000000. Edge 5: guard. Edge 6: oDigitSel=4'b1101.
  - Pulse iLoad with iValue=16'h12AF mid-frame -> old value displayed until next frame start; then digit0=0001110, digit1=0001000, digit2=0100100, digit3=1111001.
- Tear-free staging, two iLoads (16'h1111 then 16'h2222) in one frame -> only 2222 ever appears; no 1111 glyph.
- Leading-zero blanking and DP:
  - iValue=16'h0050, iLzbEn=1 -> digits 3 and 2 show 1111111; digit1=0010010; digit0=1000000.
  - iValue=16'h0000 -> only digit0 shows 0.
  - With iDpMask=4'b1000 -> oDP=0 during digit 3 slot only.
- iBlinkMask=4'b0001 -> digit0 glyph visible for 2 frames, blank with oDP=1 for 2 frames, repeating; digits 1-3 unaffected.
- Assert iRST_n low mid-slot with pending=1 -> outputs go to reset values within the same cycle, without waiting for a clock edge; after release, shows 0000 and the pending load is discarded.
